// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 s_memory arbitration slice.
//   RC4_AW / RC4_DW : default s_memory address / data widths
//   RC4_NREQ        : number of requesters sharing the memory
//   REQ_*           : requester indices (init loop, KSA swap, PRGA)
//   arb_state_e     : arbiter lock state
//   next_idx()      : round-robin successor of a requester index
package rc4_pkg;

  localparam int RC4_AW   = 8;
  localparam int RC4_DW   = 8;
  localparam int RC4_NREQ = 3;
  localparam int IDX_W    = 2;

  localparam logic [IDX_W-1:0] REQ_INIT = 2'd0;
  localparam logic [IDX_W-1:0] REQ_KSA  = 2'd1;
  localparam logic [IDX_W-1:0] REQ_PRGA = 2'd2;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input int nreq);
    if (int'(idx) >= nreq - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/s_mem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : candidate request vector
//   ptr   : index that has highest priority this cycle
//   gnt   : one-hot winner (zero when no candidate)
//   idx   : binary index of the winner
//   valid : at least one candidate present
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  // Doubling the vector turns the circular search into a plain shift:
  // bit k of rot is requester (ptr + k) mod NREQ.
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW:0]       sum;

  assign dbl = {req, req};

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    rot   = NREQ'(dbl >> ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(k);
        if (sum >= (IW+1)'(NREQ)) begin
          sum = sum - (IW+1)'(NREQ);
        end
        idx = sum[IW-1:0];
      end
    end
    if (valid) begin
      gnt = ONE << idx;
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// Arbiter for the single-port RC4 s_memory shared by the init loop, the
// KSA swap engine and the PRGA. One transaction is accepted per cycle,
// registered onto the memory port, and read data is routed back to the
// issuer RD_LAT+1 cycles later. A requester can lock the memory across a
// multi-access swap sequence.
//   clk, reset          : clock, async active-high reset
//   req/req_we/req_lock : per-requester request, write flag, keep-lock flag
//   req_addr/req_wdata  : packed per-requester address / write data
//   gnt                 : one-hot accept strobe (same cycle as req)
//   rvalid/rdata        : one-hot read return pulse and shared read data
//   mem_address/mem_data/mem_wren/mem_q : memory port
//   owner/locked        : current lock owner and lock status
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_UNLOCKED | all requesters compete, round-robin from ptr
// ST_LOCKED   | only req[owner] may be granted, others stall
module s_mem_arbiter
  import rc4_pkg::*;
#(
  parameter int NREQ   = RC4_NREQ,
  parameter int AW     = RC4_AW,
  parameter int DW     = RC4_DW,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     mem_address,
  output logic [DW-1:0]     mem_data,
  output logic              mem_wren,
  input  logic [DW-1:0]     mem_q,
  output logic [1:0]        owner,
  output logic              locked
);

  localparam int TAGS = 1 + RD_LAT;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic             wren_q, wren_d;

  // Read tag pipeline: stage 0 aligns with the address on the port, the last
  // stage aligns with mem_q being valid.
  logic             tag_vld_q [TAGS];
  logic             tag_vld_d [TAGS];
  logic [IDX_W-1:0] tag_id_q  [TAGS];
  logic [IDX_W-1:0] tag_id_d  [TAGS];

  logic [NREQ-1:0]  owner_mask;
  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             accept;

  logic             sel_we;
  logic             sel_lock;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_data;

  assign owner_mask = ONE << owner_q;

  always_comb begin
    cand = req;
    if (state_q == ST_LOCKED) begin
      cand = req & owner_mask;
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IDX_W)
  ) u_rr_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .gnt   (pick_oh),
    .idx   (pick_idx),
    .valid (pick_any)
  );

  // gnt is combinational, so it must be forced low while reset is held.
  assign accept = pick_any & ~reset;
  assign gnt    = accept ? pick_oh : '0;

  always_comb begin
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) begin
        sel_we   = req_we[i];
        sel_lock = req_lock[i];
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_wdata[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    if (accept) begin
      addr_d = sel_addr;
      data_d = sel_data;
      wren_d = sel_we;
      if (sel_lock) begin
        state_d = ST_LOCKED;
        owner_d = pick_idx;
      end else begin
        state_d = ST_UNLOCKED;
        ptr_d   = next_idx(pick_idx, NREQ);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < TAGS; k++) begin
      tag_vld_d[k] = 1'b0;
      tag_id_d[k]  = '0;
    end
    tag_vld_d[0] = accept & ~sel_we;
    tag_id_d[0]  = pick_idx;
    for (int k = 1; k < TAGS; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_UNLOCKED;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      for (int k = 0; k < TAGS; k++) begin
        tag_vld_q[k] <= 1'b0;
        tag_id_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      for (int k = 0; k < TAGS; k++) begin
        tag_vld_q[k] <= tag_vld_d[k];
        tag_id_q[k]  <= tag_id_d[k];
      end
    end
  end

  assign rvalid      = tag_vld_q[TAGS-1] ? (ONE << tag_id_q[TAGS-1]) : '0;
  assign rdata       = (|rvalid) ? mem_q : '0;
  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;
  assign owner       = owner_q;
  assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_s_mem_arbiter.sv
// Bench for s_mem_arbiter: directed steps with literal expectations plus a
// per-cycle comparison against a transaction-level model of the arbiter.
module tb_s_mem_arbiter;
  import rc4_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  req, req_we, req_lock;
  logic [23:0] req_addr, req_wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, mem_address, mem_data, mem_q;
  logic        mem_wren;
  logic [1:0]  owner;
  logic        locked;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  s_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q),
    .owner       (owner),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the port: one-cycle registered read, unwritten words
  // hold addr ^ 8'h3C.
  bit         ram_w [256];
  logic [7:0] ram   [256];
  always @(posedge clk) begin
    mem_q <= ram_w[mem_address] ? ram[mem_address] : (mem_address ^ 8'h3C);
    if (mem_wren) begin
      ram[mem_address]   <= mem_data;
      ram_w[mem_address] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct { int due; int id; logic [7:0] data; } pend_t;
  pend_t      pend[$];
  int         m_ptr, m_owner;
  bit         m_locked;
  logic [7:0] m_addr, m_data;
  logic       m_wren;
  bit         sh_w [256];
  logic [7:0] sh   [256];

  function automatic int model_pick(input logic [2:0] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int k = 0; k < 3; k++) begin
      if (r[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int         w;
    logic [2:0] exp_rv, exp_g;
    logic [7:0] exp_rd, a;
    cyc++;
    if (reset) begin
      pend.delete();
      m_ptr = 0; m_owner = 0; m_locked = 0;
      m_addr = 0; m_data = 0; m_wren = 0;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_wren", 32'(mem_wren), 0);
      chk("rst_addr", 32'(mem_address), 0);
      chk("rst_data", 32'(mem_data), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_owner", 32'(owner), 0);
    end else begin
      exp_rv = 0; exp_rd = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_rv = 3'b001 << pend[0].id;
        exp_rd = pend[0].data;
        void'(pend.pop_front());
      end
      chk("m_rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv != 0) chk("m_rdata", 32'(rdata), 32'(exp_rd));
      chk("m_wren", 32'(mem_wren), 32'(m_wren));
      chk("m_addr", 32'(mem_address), 32'(m_addr));
      chk("m_data", 32'(mem_data), 32'(m_data));
      chk("m_locked", 32'(locked), 32'(m_locked));
      if (m_locked) chk("m_owner", 32'(owner), 32'(m_owner));
      w = model_pick(req);
      exp_g = (w < 0) ? 3'b000 : (3'b001 << w);
      chk("m_gnt", 32'(gnt), 32'(exp_g));
      if (w >= 0) begin
        a      = req_addr[w*8 +: 8];
        m_addr = a;
        m_data = req_wdata[w*8 +: 8];
        m_wren = req_we[w];
        if (req_we[w]) begin
          sh[a] = m_data; sh_w[a] = 1'b1;
        end else begin
          pend.push_back('{cyc + 2, w, sh_w[a] ? sh[a] : (a ^ 8'h3C)});
        end
        if (req_lock[w]) begin
          m_locked = 1; m_owner = w;
        end else begin
          m_locked = 0; m_ptr = (w + 1) % 3;
        end
      end else begin
        m_wren = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [23:0] pk(input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
    return {a2, a1, a0};
  endfunction

  task automatic step(input logic [2:0] r, input logic [2:0] we, input logic [2:0] lk,
                      input logic [23:0] a, input logic [23:0] d,
                      output logic [2:0] g, output logic [2:0] rv, output logic [7:0] rd,
                      output logic wr, output logic [7:0] ad);
    req = r; req_we = we; req_lock = lk; req_addr = a; req_wdata = d;
    @(negedge clk);
    g = gnt; rv = rvalid; rd = rdata; wr = mem_wren; ad = mem_address;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] g, rv;
    logic [7:0] rd, ad;
    logic       wr;
    logic [2:0] exp_g1 [6];
    logic [2:0] g1 [8];
    logic [2:0] rv1 [8];
    logic [7:0] rd1 [8];

    reset = 1'b1;
    req = 0; req_we = 0; req_lock = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: all three read continuously -> strict rotation, rvalid two cycles later
    exp_g1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 8; k++) begin
      step((k < 6) ? 3'b111 : 3'b000, 3'b000, 3'b000, pk(8'h33, 8'h22, 8'h11), 24'h0,
           g1[k], rv1[k], rd1[k], wr, ad);
    end
    for (int k = 0; k < 6; k++) chk("rr_gnt", 32'(g1[k]), 32'(exp_g1[k]));
    for (int k = 2; k < 8; k++) chk("rr_rvalid", 32'(rv1[k]), 32'(exp_g1[k-2]));
    chk("rr_rdata0", 32'(rd1[2]), 32'h2D);
    chk("rr_rdata1", 32'(rd1[3]), 32'h1E);
    chk("rr_rdata2", 32'(rd1[4]), 32'h0F);

    // 2: write by 0 then read-after-write by 1 on the same address
    step(3'b001, 3'b001, 3'b000, pk(8'h00, 8'h00, 8'h05), pk(8'h00, 8'h00, 8'hA5), g, rv, rd, wr, ad);
    chk("raw_gnt_w", 32'(g), 32'h1);
    step(3'b010, 3'b000, 3'b000, pk(8'h00, 8'h05, 8'h00), 24'h0, g, rv, rd, wr, ad);
    chk("raw_gnt_r", 32'(g), 32'h2);
    chk("raw_wren", 32'(wr), 32'h1);
    step(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, g, rv, rd, wr, ad);
    step(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, g, rv, rd, wr, ad);
    chk("raw_rvalid", 32'(rv), 32'h2);
    chk("raw_rdata", 32'(rd), 32'hA5);

    // 3: KSA lock sequence; requester 0 asks for a lock too but must wait
    step(3'b001, 3'b000, 3'b000, pk(8'h00, 8'h00, 8'h01), 24'h0, g, rv, rd, wr, ad);
    chk("lk_pre_gnt", 32'(g), 32'h1);
    step(3'b111, 3'b000, 3'b011, pk(8'hAA, 8'h10, 8'hBB), 24'h0, g, rv, rd, wr, ad);
    chk("lk_rd_gnt", 32'(g), 32'h2);
    chk("lk_locked", 32'(locked), 32'h1);
    chk("lk_owner", 32'(owner), 32'(REQ_KSA));
    step(3'b111, 3'b010, 3'b011, pk(8'hAA, 8'h20, 8'hBB), pk(8'h00, 8'h55, 8'h00), g, rv, rd, wr, ad);
    chk("lk_wr_gnt", 32'(g), 32'h2);
    step(3'b111, 3'b010, 3'b001, pk(8'hAA, 8'h10, 8'hBB), pk(8'h00, 8'h66, 8'h00), g, rv, rd, wr, ad);
    chk("lk_rel_gnt", 32'(g), 32'h2);
    chk("lk_released", 32'(locked), 32'h0);
    step(3'b101, 3'b000, 3'b001, pk(8'hAA, 8'h00, 8'hBB), 24'h0, g, rv, rd, wr, ad);
    chk("lk_next_prga", 32'(g), 32'h4);
    step(3'b001, 3'b000, 3'b001, pk(8'h00, 8'h00, 8'hBB), 24'h0, g, rv, rd, wr, ad);
    chk("lk_init_gnt", 32'(g), 32'h1);
    chk("lk_init_owner", 32'(owner), 32'(REQ_INIT));
    step(3'b001, 3'b000, 3'b000, pk(8'h00, 8'h00, 8'hBC), 24'h0, g, rv, rd, wr, ad);
    chk("lk_init_rel", 32'(g), 32'h1);

    // 4: owner 1 holds the lock but goes idle; requester 0 must stall
    step(3'b010, 3'b000, 3'b010, pk(8'h00, 8'h40, 8'h00), 24'h0, g, rv, rd, wr, ad);
    chk("idle_lk_gnt", 32'(g), 32'h2);
    for (int k = 0; k < 5; k++) begin
      step(3'b001, 3'b000, 3'b000, pk(8'h00, 8'h00, 8'h99), 24'h0, g, rv, rd, wr, ad);
      chk("idle_gnt", 32'(g), 32'h0);
      chk("idle_wren", 32'(wr), 32'h0);
      chk("idle_addr", 32'(ad), 32'h40);
    end
    step(3'b010, 3'b010, 3'b000, pk(8'h00, 8'h41, 8'h00), pk(8'h00, 8'h77, 8'h00), g, rv, rd, wr, ad);
    chk("idle_rel_gnt", 32'(g), 32'h2);

    // 5: reset right after a read is accepted drops the read
    step(3'b001, 3'b000, 3'b000, pk(8'h00, 8'h00, 8'h77), 24'h0, g, rv, rd, wr, ad);
    chk("rr_before_rst", 32'(g), 32'h1);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(3'b111, 3'b000, 3'b000, pk(8'h33, 8'h22, 8'h11), 24'h0, g, rv, rd, wr, ad);
      chk("mid_rst_gnt", 32'(g), 32'h0);
      chk("mid_rst_rvalid", 32'(rv), 32'h0);
    end
    reset = 1'b0;
    chk("post_rst_locked", 32'(locked), 32'h0);
    chk("post_rst_addr", 32'(mem_address), 32'h0);
    step(3'b111, 3'b000, 3'b000, pk(8'h33, 8'h22, 8'h11), 24'h0, g, rv, rd, wr, ad);
    chk("post_rst_ptr0", 32'(g), 32'h1);
    chk("post_rst_norv", 32'(rv), 32'h0);

    // 6: PRGA back-to-back reads at the address extremes
    step(3'b100, 3'b000, 3'b000, pk(8'hFF, 8'h00, 8'h00), 24'h0, g, rv, rd, wr, ad);
    chk("edge_gnt_ff", 32'(g), 32'h4);
    step(3'b100, 3'b000, 3'b000, pk(8'h00, 8'h00, 8'h00), 24'h0, g, rv, rd, wr, ad);
    chk("edge_gnt_00", 32'(g), 32'h4);
    step(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, g, rv, rd, wr, ad);
    chk("edge_rv_ff", 32'(rv), 32'h4);
    chk("edge_rd_ff", 32'(rd), 32'hC3);
    step(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, g, rv, rd, wr, ad);
    chk("edge_rv_00", 32'(rv), 32'h4);
    chk("edge_rd_00", 32'(rd), 32'h3C);
    step(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, g, rv, rd, wr, ad);
    step(3'b000, 3'b000, 3'b000, 24'h0, 24'h0, g, rv, rd, wr, ad);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/s_mem_arbiter.md
Name: s_mem_arbiter

Overview:
- Shares the single-port 256x8 s_memory between three RC4 requesters: init loop, KSA swap engine, PRGA.
- Each requester issues one-word read/write transactions over a req/gnt handshake. The block registers the winning transaction onto the memory port and routes read data back to the issuer.
- A lock lets the KSA/PRGA keep the memory across the read i / read j / write j / write i swap sequence.
- Replaces the sel-based muxing of address/data/wren at top level.

Parameters:
- NREQ, 3, number of requesters.
- AW, 8, memory address width.
- DW, 8, memory data width.
- RD_LAT, 1, cycles from mem_address appearing on the port to mem_q valid.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester transaction request
- req_we  in  NREQ  1 = write, 0 = read
- req_lock  in  NREQ  1 = keep ownership after this transaction
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  packed write data
- gnt  out  NREQ  one-hot accept strobe, combinational, same cycle as the request
- rvalid  out  NREQ  one-hot read-data-valid pulse
- rdata  out  DW  read data, shared; qualified by rvalid
- mem_address  out  AW  registered memory address
- mem_data  out  DW  registered memory write data
- mem_wren  out  1  registered memory write enable
- mem_q  in  DW  memory read data
- owner  out  2  current lock owner index; meaningful only when locked=1
- locked  out  1  lock held

Behaviour:
- Reset (async): gnt=0, rvalid=0, mem_wren=0, mem_address=0, mem_data=0, locked=0, owner=0, round-robin pointer=0, read tag pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced.
- States:
  - UNLOCKED: candidates are all asserted req bits. Round-robin search starts at pointer ptr.
  - LOCKED: the only candidate is req[owner]. Other requesters stall with gnt=0.
- Accept in cycle t: gnt[i]=1 for exactly one i. At the edge ending t:
  - mem_address<=addr_i, mem_data<=wdata_i, mem_wren<=req_we[i].
  - If req_lock[i]=1: go to or stay in LOCKED with owner=i. Else: go to UNLOCKED and ptr<=(i+1) mod NREQ.
- While LOCKED, ptr is not updated.
- No accept in a cycle: mem_wren<=0. mem_address and mem_data hold.
- Throughput: one accept per cycle. A requester may hold req across cycles; every gnt cycle is a separate transaction.
- Read accepted in cycle t: rvalid[i]=1 in cycle t+1+RD_LAT (default t+2), with rdata=mem_q in that cycle.
- Tag pipeline: depth 1+RD_LAT, carrying valid plus a 2-bit id.
- Writes never produce rvalid.
- Read accepted in cycle t+1 after a write accepted in cycle t, same address: returns the new data.
- A lock is released only by a granted transaction from the owner with req_lock=0. If the owner idles, the lock is held indefinitely.
- A req_lock from a non-owner while LOCKED has no effect until that requester is granted.
- Requester index >= NREQ is never granted.

Decomposition:
- rc4_pkg holds:
  - AW and DW defaults.
  - Requester indices REQ_INIT=0, REQ_KSA=1, REQ_PRGA=2.
  - State enum {ST_UNLOCKED, ST_LOCKED}.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant and index.

Test Plan:
- Reset, then req=3'b111 with all reads, held 6 cycles -> gnt order 001,010,100,001,010,100; rvalid follows each grant 2 cycles later with matching one-hot.
- Requester 0 writes addr 8'h05 data 8'hA5 in cycle t; requester 1 reads addr 8'h05 in cycle t+1 -> mem_wren=1 in t+1; rvalid[1]=1 and rdata=8'hA5 in t+3.
- KSA (1) reads 8'h10 with lock=1, while requesters 0 and 2 hold req -> locked=1, owner=1. Only gnt[1] appears through its lock=1 read, lock=1 write and final lock=0 write; then gnt[2] (ptr=2) is granted next.
- Owner 1 locked and deasserts req for 5 cycles while req[0]=1 -> gnt=000, mem_wren=0, and mem_address holds through all 5 cycles.
- Read accepted, then reset asserted the next cycle -> no rvalid ever appears, all outputs zero, ptr=0, locked=0.
- Requester 2 issues back-to-back reads of 8'hFF then 8'h00 -> two consecutive rvalid[2] pulses with rdata in address order; the 8-bit address passes through with no wrap error.
